// File: rtl/locking_rr_arbiter_n.sv
// Round-robin arbiter for N message ports. A beat flagged with in_lock pins
// the grant to its port until a BEATS-beat burst has fully transferred.
module locking_rr_arbiter_n #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 64,
  parameter int BEATS  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_IN-1:0]           in_valid,
  output logic [N_IN-1:0]           in_ready,
  input  logic [N_IN-1:0]           in_lock,
  input  logic [N_IN*DATA_W-1:0]    in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(N_IN)-1:0]   out_chosen,
  output logic                      out_locked
);

  localparam int CHOSEN_W = $clog2(N_IN);
  localparam int CNT_W    = $clog2(BEATS);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [CHOSEN_W-1:0] LAST_PORT  = CHOSEN_W'(N_IN - 1);
  localparam logic [CNT_W-1:0]    FINAL_BEAT = CNT_W'(BEATS - 1);

  logic [0:0]          state_reg, state_next;
  logic [CHOSEN_W-1:0] lock_owner_reg, lock_owner_next;
  logic [CNT_W-1:0]    beat_cnt_reg, beat_cnt_next;
  logic [CHOSEN_W-1:0] last_grant_reg, last_grant_next;

  logic [DATA_W-1:0]   port_data [N_IN];
  logic [CHOSEN_W-1:0] choice;
  logic [CHOSEN_W-1:0] upper_idx, lower_idx;
  logic                upper_hit, lower_hit;
  logic [CHOSEN_W-1:0] chosen;
  logic                sel_valid;
  logic [DATA_W-1:0]   sel_data;
  logic                fire;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_unpack
      assign port_data[gi] = in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan high-to-low so the last hit is the lowest index; the upper set
  // (ports above last_grant) takes priority over the wrap-around set.
  always_comb begin
    upper_hit = 1'b0;
    lower_hit = 1'b0;
    upper_idx = '0;
    lower_idx = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lower_hit = 1'b1;
        lower_idx = CHOSEN_W'(i);
        if (CHOSEN_W'(i) > last_grant_reg) begin
          upper_hit = 1'b1;
          upper_idx = CHOSEN_W'(i);
        end
      end
    end
    if (upper_hit) begin
      choice = upper_idx;
    end else if (lower_hit) begin
      choice = lower_idx;
    end else begin
      choice = LAST_PORT;
    end
  end

  assign chosen = (state_reg == LOCKED) ? lock_owner_reg : choice;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (chosen == CHOSEN_W'(i)) begin
        sel_valid = in_valid[i];
        sel_data  = port_data[i];
      end
    end
  end

  assign out_valid  = sel_valid & ~reset;
  assign out_data   = sel_data;
  assign out_chosen = chosen;
  assign out_locked = (state_reg == LOCKED);
  assign fire       = out_valid & out_ready;

  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_ready
      assign in_ready[gi] = out_ready & ~reset & (chosen == CHOSEN_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    lock_owner_next = lock_owner_reg;
    beat_cnt_next   = beat_cnt_reg;
    last_grant_next = last_grant_reg;
    if (fire) begin
      last_grant_next = chosen;
      case (state_reg)
        IDLE: begin
          if (in_lock[chosen]) begin
            state_next      = LOCKED;
            lock_owner_next = chosen;
            beat_cnt_next   = CNT_W'(1);
          end
        end
        default: begin
          // Every owner beat counts toward the burst; in_lock is ignored here.
          if (beat_cnt_reg == FINAL_BEAT) begin
            state_next    = IDLE;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      lock_owner_reg <= '0;
      beat_cnt_reg   <= '0;
      last_grant_reg <= LAST_PORT;
    end else begin
      state_reg      <= state_next;
      lock_owner_reg <= lock_owner_next;
      beat_cnt_reg   <= beat_cnt_next;
      last_grant_reg <= last_grant_next;
    end
  end

endmodule

// File: tb/tb_locking_rr_arbiter_n.sv
// Bench for locking_rr_arbiter_n: directed vector table, mid-burst corner
// sequences, and random traffic against a rotation-based reference model.
module tb_locking_rr_arbiter_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [4:0]  v, lk;
  logic [63:0] d [5];
  logic        out_ready;

  logic [3:0]   a_valid_in, a_ready, a_lock_in;
  logic [255:0] a_in_data;
  logic         a_valid, a_locked;
  logic [63:0]  a_data;
  logic [1:0]   a_chosen;

  logic [4:0]   b_valid_in, b_ready, b_lock_in;
  logic [79:0]  b_in_data;
  logic         b_valid, b_locked;
  logic [15:0]  b_data;
  logic [2:0]   b_chosen;

  logic [2:0]  g_chosen;
  logic        g_valid, g_locked;
  logic [4:0]  g_ready;
  logic [63:0] g_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign a_valid_in = sel ? 4'b0 : v[3:0];
  assign a_lock_in  = lk[3:0];
  assign b_valid_in = sel ? v : 5'b0;
  assign b_lock_in  = lk;

  always_comb begin
    a_in_data = '0;
    b_in_data = '0;
    for (int i = 0; i < 4; i++) a_in_data[i*64 +: 64] = d[i];
    for (int i = 0; i < 5; i++) b_in_data[i*16 +: 16] = d[i][15:0];
  end

  locking_rr_arbiter_n #(.N_IN(4), .DATA_W(64), .BEATS(8)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_valid_in), .in_ready(a_ready), .in_lock(a_lock_in), .in_data(a_in_data),
    .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data),
    .out_chosen(a_chosen), .out_locked(a_locked)
  );

  locking_rr_arbiter_n #(.N_IN(5), .DATA_W(16), .BEATS(4)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_valid_in), .in_ready(b_ready), .in_lock(b_lock_in), .in_data(b_in_data),
    .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data),
    .out_chosen(b_chosen), .out_locked(b_locked)
  );

  always_comb begin
    if (!sel) begin
      g_chosen = {1'b0, a_chosen};
      g_valid  = a_valid;
      g_locked = a_locked;
      g_ready  = {1'b0, a_ready};
      g_data   = a_data;
    end else begin
      g_chosen = b_chosen;
      g_valid  = b_valid;
      g_locked = b_locked;
      g_ready  = b_ready;
      g_data   = {48'b0, b_data};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: arbitration as a rotating search starting after the
  // last granted port, with a burst tracked as "beats done so far".
  typedef struct {
    int last;
    bit locked;
    int owner;
    int done;
  } mstate_t;

  function automatic int m_choice(mstate_t s, int n, logic [4:0] vv);
    if (s.locked) return s.owner;
    for (int k = 1; k <= n; k++) begin
      int p = (s.last + k) % n;
      if (vv[p]) return p;
    end
    return n - 1;
  endfunction

  function automatic mstate_t m_step(mstate_t s, int ch, bit lock_bit, int beats);
    mstate_t r = s;
    r.last = ch;
    if (r.locked) begin
      r.done++;
      if (r.done == beats) begin
        r.locked = 0;
        r.done   = 0;
      end
    end else if (lock_bit) begin
      r.locked = 1;
      r.owner  = ch;
      r.done   = 1;
    end
    return r;
  endfunction

  typedef struct {
    logic [3:0] v;
    logic [3:0] lk;
    logic       rdy;
    int         ch;
    logic       ev;
    logic       el;
    logic [3:0] er;
  } vec_t;

  vec_t tbl [$];

  task automatic addv(input logic [3:0] vv, input logic [3:0] ll, input logic r,
                      input int ch, input logic ev, input logic el, input logic [3:0] er);
    vec_t t;
    t.v = vv; t.lk = ll; t.rdy = r; t.ch = ch; t.ev = ev; t.el = el; t.er = er;
    tbl.push_back(t);
  endtask

  // Reset with all ports requesting; outputs must stay quiet while reset is high.
  task automatic do_reset();
    reset = 1'b1;
    v = 5'b11111;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(g_valid), 64'd0);
    check("rst_in_ready", 64'(g_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    v = '0;
    lk = '0;
    out_ready = 1'b0;
  endtask

  task automatic rand_run(input int n, input int beats, input int cycles);
    mstate_t st;
    logic [63:0] mask;
    logic [63:0] exp_q [5][$];
    int ch;
    bit ev, fire;
    mask = (n == 4) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
    for (int p = 0; p < 5; p++) exp_q[p].delete();
    do_reset();
    @(negedge clk);
    check("rand_rst_locked", 64'(g_locked), 64'd0);
    @(posedge clk); #1;
    st.last = n - 1; st.locked = 0; st.owner = 0; st.done = 0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      for (int p = 0; p < n; p++) begin
        if (!v[p] && $urandom_range(0, 2) != 0) begin
          v[p]  = 1'b1;
          d[p]  = {$urandom(), $urandom()};
          lk[p] = ($urandom_range(0, 3) == 0);
          exp_q[p].push_back(d[p] & mask);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ch   = m_choice(st, n, v);
      ev   = v[ch];
      fire = ev & out_ready;
      check("rand_chosen", 64'(g_chosen), 64'(ch));
      check("rand_valid", 64'(g_valid), 64'(ev));
      check("rand_locked", 64'(g_locked), 64'(st.locked));
      check("rand_ready", 64'(g_ready), out_ready ? 64'(1 << ch) : 64'd0);
      if (fire) begin
        check("rand_order", g_data, exp_q[ch][0]);
        $display("fire n=%0d port=%0d data=%h locked=%0b", n, ch, g_data, st.locked);
        void'(exp_q[ch].pop_front());
        st = m_step(st, ch, lk[ch], beats);
      end
      @(posedge clk); #1;
      if (fire) v[ch] = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fires, guard, ch;
    sel = 1'b0;
    reset = 1'b1;
    v = '0;
    lk = '0;
    out_ready = 1'b0;
    for (int p = 0; p < 5; p++) d[p] = 64'hD00D_0000_0000_0000 | 64'(p);

    // Round robin over all ports, wrap-around priority, then an 8-beat lock.
    for (int k = 0; k < 6; k++) addv(4'b1111, 4'b0000, 1'b1, k % 4, 1'b1, 1'b0, 4'(1 << (k % 4)));
    addv(4'b1001, 4'b0000, 1'b1, 3, 1'b1, 1'b0, 4'b1000);
    addv(4'b1001, 4'b0000, 1'b1, 0, 1'b1, 1'b0, 4'b0001);
    addv(4'b0010, 4'b0000, 1'b1, 1, 1'b1, 1'b0, 4'b0010);
    addv(4'b0111, 4'b0100, 1'b1, 2, 1'b1, 1'b0, 4'b0100);
    for (int b = 2; b <= 8; b++) begin
      if (b == 4) addv(4'b0111, 4'b0000, 1'b0, 2, 1'b1, 1'b1, 4'b0000);
      addv(4'b0111, 4'b0000, 1'b1, 2, 1'b1, 1'b1, 4'b0100);
    end
    addv(4'b0111, 4'b0000, 1'b1, 0, 1'b1, 1'b0, 4'b0001);
    addv(4'b0000, 4'b0000, 1'b1, 3, 1'b0, 1'b0, 4'b1000);

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("reset_locked", 64'(g_locked), 64'd0);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      v = {1'b0, tbl[i].v};
      lk = {1'b0, tbl[i].lk};
      out_ready = tbl[i].rdy;
      @(negedge clk);
      $display("vec %0d: chosen=%0d valid=%0b locked=%0b ready=%b", i, g_chosen, g_valid, g_locked, g_ready);
      check($sformatf("vec%0d_chosen", i), 64'(g_chosen), 64'(tbl[i].ch));
      check($sformatf("vec%0d_valid", i), 64'(g_valid), 64'(tbl[i].ev));
      check($sformatf("vec%0d_locked", i), 64'(g_locked), 64'(tbl[i].el));
      check($sformatf("vec%0d_ready", i), 64'(g_ready), 64'(tbl[i].er));
      check($sformatf("vec%0d_data", i), g_data, d[tbl[i].ch]);
      @(posedge clk); #1;
    end

    // Owner stalls mid-burst while out_ready toggles; others must stay blocked.
    do_reset();
    v = 5'b00010; lk = 5'b00010; out_ready = 1'b1;
    @(negedge clk);
    check("t4_first_chosen", 64'(g_chosen), 64'd1);
    @(posedge clk); #1;
    fires = 1;
    lk = '0;
    v = 5'b01111;
    repeat (2) begin
      @(negedge clk);
      check("t4_lock_ready", 64'(g_ready), 64'b0010);
      @(posedge clk); #1;
      fires++;
    end
    v = 5'b01101;
    repeat (3) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("t4_stall_valid", 64'(g_valid), 64'd0);
      check("t4_stall_chosen", 64'(g_chosen), 64'd1);
      check("t4_stall_ready", 64'(g_ready), out_ready ? 64'b0010 : 64'd0);
      check("t4_stall_cnt", 64'(dut_a.beat_cnt_reg), 64'd3);
      @(posedge clk); #1;
    end
    v = 5'b01111;
    guard = 0;
    while (fires < 8 && guard < 100) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("t4_burst_locked", 64'(g_locked), 64'd1);
      check("t4_burst_ready", 64'(g_ready), out_ready ? 64'b0010 : 64'd0);
      if (out_ready) fires++;
      @(posedge clk); #1;
      guard++;
    end
    check("t4_beat_budget", 64'(fires), 64'd8);
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_after_locked", 64'(g_locked), 64'd0);
    check("t4_after_chosen", 64'(g_chosen), 64'd2);
    @(posedge clk); #1;

    // Reset after beat 4 abandons the burst.
    do_reset();
    v = 5'b00001; lk = 5'b00001; out_ready = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      check("t5_burst_chosen", 64'(g_chosen), 64'd0);
      @(posedge clk); #1;
      lk = '0;
    end
    check("t5_mid_cnt", 64'(dut_a.beat_cnt_reg), 64'd4);
    do_reset();
    v = 5'b00110; out_ready = 1'b1;
    @(negedge clk);
    check("t5_locked", 64'(g_locked), 64'd0);
    check("t5_cnt", 64'(dut_a.beat_cnt_reg), 64'd0);
    check("t5_next_chosen", 64'(g_chosen), 64'd1);
    ch = 1;
    $display("t5 after reset: chosen=%0d expected=%0d", g_chosen, ch);
    @(posedge clk); #1;

    sel = 1'b0;
    rand_run(4, 8, 800);
    sel = 1'b1;
    rand_run(5, 4, 800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
